product_accumulator: RTL and testbench

//  Downstream stage for the 16x16 array multiplier: sums its 32-bit products into a wide register.
//  - Sequential, with a valid/ready handshake on the input and on the output.
//  - A packet of terms ends when in_last is accepted, or when MAX_TERMS terms have been accepted.
//  - At packet end the block presents the sum and the term count, then holds them until consumed.
//  - Forms the accumulate half of the datapath's multiply-accumulate (MAC) path.

---
 rtl/product_accumulator.sv | 137 +++++++++++++
 tb/tb_product_accumulator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator
//   Accumulates unsigned 32-bit products from the 16x16 array multiplier into
//   an ACC_W-bit sum. A packet ends on an accepted beat with in_last set, or
//   when MAX_TERMS terms have been accepted. The sum and term count are then
//   held on the output handshake until they are consumed.
//
// Ports
//   clk, rst     single clock; synchronous active-high reset
//   clear        synchronous abort of the partial or held packet
//   in_valid/in_ready/in_product/in_last   product beat handshake
//   out_valid/out_ready/out_data/out_count result handshake
//   overflow     sticky; set when a carry leaves bit ACC_W-1 during the packet
//
// Configuration
//   PRODUCT_ACC_SATURATE_EN  defined: the sum clamps to all ones on carry out
//                            and stays clamped for the rest of the packet;
//                            undefined: the sum wraps modulo 2**ACC_W.
module product_accumulator #(
   parameter int unsigned ACC_W     = 40,
   parameter int unsigned MAX_TERMS = 256,
   parameter int unsigned CNT_W     = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_product,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             overflow
);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [ACC_W-1:0]   out_data_q, out_data_d;
   logic [CNT_W-1:0]   out_count_q, out_count_d;

   logic [ACC_W:0]     sum;
   logic               carry;
   logic [ACC_W-1:0]   acc_next;
   logic [CNT_W-1:0]   cnt_inc;
   logic               pkt_end;

   always_comb begin
      sum      = {1'b0, acc_q} + (ACC_W+1)'(in_product);
      carry    = sum[ACC_W];
`ifdef PRODUCT_ACC_SATURATE_EN
      // once clamped, stay clamped until the packet is consumed or aborted
      acc_next = (carry || ovf_q) ? '1 : sum[ACC_W-1:0];
`else
      acc_next = sum[ACC_W-1:0];
`endif
      cnt_inc  = cnt_q + CNT_W'(1);
      pkt_end  = in_last || (cnt_inc == CNT_W'(MAX_TERMS));
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;

      if (clear) begin
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
         state_d = ACCUM;
         if (state_q == HOLD) begin
            out_data_d  = '0;
            out_count_d = '0;
         end
      end else begin
         case (state_q)
            ACCUM: begin
               if (in_valid) begin
                  acc_d = acc_next;
                  cnt_d = cnt_inc;
                  ovf_d = ovf_q | carry;
                  if (pkt_end) begin
                     out_data_d  = acc_next;
                     out_count_d = cnt_inc;
                     state_d     = HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = ACCUM;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
      end
   end

   // rst is folded in so the input side is closed while reset is held
   assign in_ready  = (state_q == ACCUM) && !rst;
   assign out_valid = (state_q == HOLD);
   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
//   Directed bench for product_accumulator built with ACC_W=32, MAX_TERMS=4,
//   CNT_W=3 so that wrap/overflow and the forced packet end are reachable.
module tb_product_accumulator;

   localparam int unsigned ACC_W     = 32;
   localparam int unsigned MAX_TERMS = 4;
   localparam int unsigned CNT_W     = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_product;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic [CNT_W-1:0] out_count;
   logic             overflow;

   int unsigned tests = 0;
   int unsigned fails = 0;

   product_accumulator #(
      .ACC_W    (ACC_W),
      .MAX_TERMS(MAX_TERMS),
      .CNT_W    (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_product(in_product),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   logic [31:0] hold_data;

   initial begin
      // T1 reset with in_valid asserted
      rst        = 1'b1;
      clear      = 1'b0;
      in_valid   = 1'b1;
      in_product = 32'h5;
      in_last    = 1'b0;
      out_ready  = 1'b0;
      step();
      step();
      check("rst_in_ready",  64'(in_ready),  64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data",  64'(out_data),  64'd0);
      check("rst_out_count", 64'(out_count), 64'd0);
      check("rst_overflow",  64'(overflow),  64'd0);
      rst      = 1'b0;
      in_valid = 1'b0;
      step();
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      // T2 three-beat packet
      in_valid = 1'b1; in_product = 32'h0000_0006; in_last = 1'b0;
      step();
      check("t2_mid_out_valid", 64'(out_valid), 64'd0);
      in_product = 32'hFFFE_0001;
      step();
      in_product = 32'h0000_0010; in_last = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      check("t2_out_valid", 64'(out_valid), 64'd1);
      check("t2_out_data",  64'(out_data),  64'hFFFE_0017);
      check("t2_out_count", 64'(out_count), 64'd3);
      check("t2_overflow",  64'(overflow),  64'd0);
      check("t2_in_ready",  64'(in_ready),  64'd0);

      // T3 backpressure while inputs toggle
      hold_data = 32'hFFFE_0017;
      for (int i = 0; i < 5; i++) begin
         in_valid   = (i % 2 == 0);
         in_product = 32'h1234_0000 + 32'(i);
         in_last    = 1'b1;
         step();
         check("t3_hold_valid", 64'(out_valid), 64'd1);
         check("t3_hold_data",  64'(out_data),  64'(hold_data));
         check("t3_hold_ready", 64'(in_ready),  64'd0);
      end
      in_valid = 1'b0; in_last = 1'b0;
      check("t3_hold_count", 64'(out_count), 64'd3);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("t3_consume_valid", 64'(out_valid), 64'd0);
      check("t3_consume_ready", 64'(in_ready),  64'd1);

      // T4 overflow at ACC_W=32
      in_valid = 1'b1; in_product = 32'hFFFE_0001; in_last = 1'b0;
      step();
      in_last = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      check("t4_out_valid", 64'(out_valid), 64'd1);
`ifdef PRODUCT_ACC_SATURATE_EN
      check("t4_out_data",  64'(out_data),  64'hFFFF_FFFF);
`else
      check("t4_out_data",  64'(out_data),  64'hFFFC_0002);
`endif
      check("t4_out_count", 64'(out_count), 64'd2);
      check("t4_overflow",  64'(overflow),  64'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("t4_ovf_cleared", 64'(overflow), 64'd0);

      // T5 forced end after MAX_TERMS beats
      in_valid = 1'b1; in_product = 32'h1; in_last = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("t5_out_valid", 64'(out_valid), 64'd1);
      check("t5_out_data",  64'(out_data),  64'd4);
      check("t5_out_count", 64'(out_count), 64'd4);
      step();
      check("t5_stall_ready", 64'(in_ready), 64'd0);
      step();
      check("t5_stall_data",  64'(out_data), 64'd4);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_last   = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      check("t5_next_valid", 64'(out_valid), 64'd1);
      check("t5_next_data",  64'(out_data),  64'd1);
      check("t5_next_count", 64'(out_count), 64'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // T6 abort mid-packet, then a single-beat packet
      in_valid = 1'b1; in_product = 32'h5; in_last = 1'b0;
      step();
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      in_product = 32'h7; in_last = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      check("t6_out_valid", 64'(out_valid), 64'd1);
      check("t6_out_data",  64'(out_data),  64'd7);
      check("t6_out_count", 64'(out_count), 64'd1);
      check("t6_overflow",  64'(overflow),  64'd0);
      rst = 1'b1;
      step();
      check("t6_rst_valid", 64'(out_valid), 64'd0);
      check("t6_rst_data",  64'(out_data),  64'd0);
      check("t6_rst_ready", 64'(in_ready),  64'd0);
      rst = 1'b0;
      step();

      // clear while holding a result discards it
      in_valid = 1'b1; in_product = 32'h9; in_last = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      check("clr_hold_pre",   64'(out_data),  64'd9);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clr_hold_valid", 64'(out_valid), 64'd0);
      check("clr_hold_data",  64'(out_data),  64'd0);
      check("clr_hold_count", 64'(out_count), 64'd0);
      check("clr_hold_ready", 64'(in_ready),  64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
